// File: rtl/bc_msg_arbiter.sv
// Round-robin arbiter sharing one broadcast-message bus among CORE_COUNT core slots.
// Disabled slots are drained and counted as drops; the winning message is registered onto the bus.
module bc_msg_arbiter #(
    parameter int CORE_COUNT    = 16,
    parameter int CORE_ID_WIDTH = 4,
    parameter int MSG_WIDTH     = 47
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_msg,
    input  logic [CORE_COUNT-1:0]           s_valid,
    output logic [CORE_COUNT-1:0]           s_ready,
    input  logic [CORE_COUNT-1:0]           core_enable,
    output logic [MSG_WIDTH-1:0]            m_msg,
    output logic                            m_valid,
    output logic [CORE_ID_WIDTH-1:0]        m_core_id,
    output logic [31:0]                     msg_count,
    output logic [15:0]                     drop_count
);

    localparam logic [CORE_ID_WIDTH-1:0] LAST_ID = CORE_ID_WIDTH'(CORE_COUNT - 1);

    // Slot index k positions after base, wrapping at CORE_COUNT (which need not be a power of 2).
    function automatic logic [CORE_ID_WIDTH-1:0] wrap_id(input logic [CORE_ID_WIDTH-1:0] base,
                                                         input int k);
        int s;
        s = int'(base) + k;
        if (s >= CORE_COUNT) s = s - CORE_COUNT;
        return CORE_ID_WIDTH'(s);
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] acc,
                                              input logic [CORE_ID_WIDTH:0] inc);
        logic [16:0] sum;
        sum = {1'b0, acc} + 17'(inc);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [CORE_COUNT-1:0]    req;
    logic [CORE_COUNT-1:0]    drop;
    logic [CORE_COUNT-1:0]    grant;
    logic                     gnt_found;
    logic [CORE_ID_WIDTH-1:0] gnt_id;
    logic [CORE_ID_WIDTH-1:0] idx;
    logic [CORE_ID_WIDTH:0]   drop_n;
    logic [MSG_WIDTH-1:0]     gnt_msg;

    logic [CORE_ID_WIDTH-1:0] rr_ptr;
    logic [MSG_WIDTH-1:0]     msg_p1;
    logic [CORE_ID_WIDTH-1:0] id_p1;
    logic                     vld_p1;
    logic [31:0]              msg_cnt_p1;
    logic [15:0]              drop_cnt_p1;

    assign req  = s_valid & core_enable;
    assign drop = rst_n ? (s_valid & ~core_enable) : '0;

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int k = 0; k < CORE_COUNT; k++) begin
            idx = wrap_id(rr_ptr, k);
            if (!gnt_found && req[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (gnt_found) grant[gnt_id] = 1'b1;
    end

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            drop_n = drop_n + (CORE_ID_WIDTH+1)'(drop[i]);
        end
    end

    // Disabled slots are always ready so their traffic drains; nothing is accepted in reset.
    assign s_ready = rst_n ? (grant | ~core_enable) : '0;
    assign gnt_msg = s_msg[int'(gnt_id)*MSG_WIDTH +: MSG_WIDTH];

    // Stage p1: registered broadcast and bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            msg_p1      <= '0;
            id_p1       <= '0;
            rr_ptr      <= '0;
            msg_cnt_p1  <= '0;
            drop_cnt_p1 <= '0;
        end else begin
            vld_p1      <= gnt_found;
            drop_cnt_p1 <= sat_add16(drop_cnt_p1, drop_n);
            if (gnt_found) begin
                msg_p1     <= gnt_msg;
                id_p1      <= gnt_id;
                rr_ptr     <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
                msg_cnt_p1 <= msg_cnt_p1 + 32'd1;
            end
        end
    end

    assign m_valid    = vld_p1;
    assign m_msg      = msg_p1;
    assign m_core_id  = id_p1;
    assign msg_count  = msg_cnt_p1;
    assign drop_count = drop_cnt_p1;

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Bench for bc_msg_arbiter: directed scenarios plus random traffic against a scan-and-count reference model.
// A second 5-slot instance exercises round-robin wrap with a non-power-of-2 slot count.
module tb_bc_msg_arbiter;

    localparam int N  = 16;
    localparam int W  = 47;
    localparam int N5 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [N*W-1:0]   s_msg;
    logic [N-1:0]     s_valid, s_ready, core_enable;
    logic [W-1:0]     m_msg;
    logic             m_valid;
    logic [3:0]       m_core_id;
    logic [31:0]      msg_count;
    logic [15:0]      drop_count;

    logic [N5*W-1:0]  s_msg5;
    logic [N5-1:0]    s_valid5, s_ready5, core_enable5;
    logic [W-1:0]     m_msg5;
    logic             m_valid5;
    logic [2:0]       m_core_id5;
    logic [31:0]      msg_count5;
    logic [15:0]      drop_count5;

    bc_msg_arbiter #(.CORE_COUNT(N), .CORE_ID_WIDTH(4), .MSG_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .s_msg(s_msg), .s_valid(s_valid), .s_ready(s_ready),
        .core_enable(core_enable), .m_msg(m_msg), .m_valid(m_valid), .m_core_id(m_core_id),
        .msg_count(msg_count), .drop_count(drop_count));

    bc_msg_arbiter #(.CORE_COUNT(N5), .CORE_ID_WIDTH(3), .MSG_WIDTH(W)) dut5 (
        .clk(clk), .rst_n(rst_n), .s_msg(s_msg5), .s_valid(s_valid5), .s_ready(s_ready5),
        .core_enable(core_enable5), .m_msg(m_msg5), .m_valid(m_valid5), .m_core_id(m_core_id5),
        .msg_count(msg_count5), .drop_count(drop_count5));

    int total = 0;
    int bad   = 0;

    logic [W-1:0] msgs [N];

    // Reference model state
    int           ref_rr = 0;
    bit           ref_vld = 0;
    logic [W-1:0] ref_msg = '0;
    int           ref_id = 0;
    logic [31:0]  ref_cnt = '0;
    int           ref_drop = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock of the 16-slot DUT: check ready before the edge, registered outputs after it.
    task automatic step(input logic rstn_i, input logic [N-1:0] v, input logic [N-1:0] en);
        int winner;
        int ndrop;
        logic [N-1:0] exp_ready;
        rst_n       = rstn_i;
        s_valid     = v;
        core_enable = en;
        for (int i = 0; i < N; i++) s_msg[i*W +: W] = msgs[i];
        #1;
        winner = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ref_rr + k) % N;
            if (v[j] && en[j]) begin
                winner = j;
                break;
            end
        end
        if (!rstn_i) exp_ready = '0;
        else begin
            exp_ready = ~en;
            if (winner >= 0) exp_ready[winner] = 1'b1;
        end
        chk("s_ready", 64'(s_ready), 64'(exp_ready));
        if (!rstn_i) begin
            ref_rr = 0; ref_vld = 0; ref_msg = '0; ref_id = 0; ref_cnt = '0; ref_drop = 0;
        end else begin
            ndrop = $countones(v & ~en);
            ref_drop = (ref_drop + ndrop > 65535) ? 65535 : ref_drop + ndrop;
            if (winner >= 0) begin
                ref_vld = 1;
                ref_msg = msgs[winner];
                ref_id  = winner;
                ref_rr  = (winner + 1) % N;
                ref_cnt = ref_cnt + 32'd1;
            end else begin
                ref_vld = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("m_valid", 64'(m_valid), 64'(ref_vld));
        chk("m_msg", 64'(m_msg), 64'(ref_msg));
        chk("m_core_id", 64'(m_core_id), 64'(ref_id));
        chk("msg_count", 64'(msg_count), 64'(ref_cnt));
        chk("drop_count", 64'(drop_count), 64'(ref_drop));
    endtask

    initial begin
        int rr_seq [6];
        int exp_seq [6];
        logic [N-1:0] rv, ren;
        logic         rrst;

        rst_n = 1'b0; s_valid = '0; core_enable = '0; s_msg = '0;
        s_valid5 = '0; core_enable5 = '0; s_msg5 = '0;
        for (int i = 0; i < N; i++) msgs[i] = W'({$urandom, $urandom});
        @(negedge clk);

        // Reset then idle
        for (int c = 0; c < 3; c++) step(1'b0, 16'hFFFF, 16'hFFFF);
        step(1'b1, 16'h0000, 16'h0000);
        chk("idle_m_valid", 64'(m_valid), 64'd0);
        chk("idle_msg_count", 64'(msg_count), 64'd0);
        chk("idle_drop_count", 64'(drop_count), 64'd0);

        // Single slot
        msgs[5] = 47'h1234;
        step(1'b1, 16'h0020, 16'hFFFF);
        chk("single_id", 64'(m_core_id), 64'd5);
        chk("single_msg", 64'(m_msg), 64'h1234);
        chk("single_cnt", 64'(msg_count), 64'd1);

        // Round-robin among 0, 3, 15 from a fresh pointer
        step(1'b0, 16'h0000, 16'hFFFF);
        exp_seq = '{0, 3, 15, 0, 3, 15};
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 16'h8009, 16'hFFFF);
            rr_seq[c] = int'(m_core_id);
            chk("rr_order", 64'(rr_seq[c]), 64'(exp_seq[c]));
        end

        // Drop from disabled slot 7 while slot 2 is served
        step(1'b0, 16'h0000, 16'hFFFF);
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 16'h0084, 16'hFF7F);
            chk("drop_src_id", 64'(m_core_id), 64'd2);
        end
        chk("drop_total", 64'(drop_count), 64'd4);

        // Reset right after a grant to slot 9
        step(1'b0, 16'h0000, 16'hFFFF);
        step(1'b1, 16'h0200, 16'hFFFF);
        chk("pre_rst_id", 64'(m_core_id), 64'd9);
        step(1'b0, 16'h0000, 16'hFFFF);
        chk("rst_mid_valid", 64'(m_valid), 64'd0);
        step(1'b1, 16'h0201, 16'hFFFF);
        chk("post_rst_first", 64'(m_core_id), 64'd0);

        // Random traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) msgs[i] = W'({$urandom, $urandom});
            rv   = N'($urandom);
            ren  = ~N'($urandom & $urandom & $urandom);
            rrst = ($urandom_range(0, 39) != 0);
            step(rrst, rv, ren);
        end

        // Drop counter saturation
        step(1'b0, 16'h0000, 16'hFFFF);
        for (int c = 0; c < 70000; c++) step(1'b1, 16'h0002, 16'hFFFD);
        chk("drop_sat", 64'(drop_count), 64'hFFFF);

        // Five-slot instance: slots 3 and 4 alternate, pointer wraps 4 -> 0
        rst_n = 1'b0; s_valid = '0; core_enable = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        core_enable5 = '1;
        s_valid5 = 5'b11000;
        for (int i = 0; i < N5; i++) s_msg5[i*W +: W] = W'(47'h5000 + i);
        for (int c = 0; c < 6; c++) begin
            int e;
            e = (c % 2 == 0) ? 3 : 4;
            #1;
            chk("n5_ready", 64'(s_ready5), 64'(5'b00001 << e));
            @(posedge clk); #1;
            chk("n5_valid", 64'(m_valid5), 64'd1);
            chk("n5_id", 64'(m_core_id5), 64'(e));
            chk("n5_msg", 64'(m_msg5), 64'(47'h5000 + e));
        end
        chk("n5_count", 64'(msg_count5), 64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
